// File: rtl/traffic_light_monitor.sv
// Passive safety monitor for the four-approach traffic light controller.
// Watches the 12 go signals, checks phase sequencing and latches a sticky coded fault.
module traffic_light_monitor #(
    parameter int CW        = 8,
    parameter int MIN_GREEN = 2,
    parameter int MAX_GREEN = 8,
    parameter int MAX_WAIT  = 40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          e2_l,
    input  logic          e2_r,
    input  logic          e2_o,
    input  logic          w2_l,
    input  logic          w2_r,
    input  logic          w2_o,
    input  logic          n2_l,
    input  logic          n2_r,
    input  logic          n2_o,
    input  logic          s2_l,
    input  logic          s2_r,
    input  logic          s2_o,
    input  logic          clr_fault,
    output logic          active_valid,
    output logic [1:0]    active_dir,
    output logic [CW-1:0] phase_len,
    output logic [7:0]    round_cnt,
    output logic          fault,
    output logic [2:0]    fault_code
);

    typedef enum logic [1:0] {ST_IDLE, ST_SERVE, ST_FAULT} state_t;
    typedef enum logic [2:0] {
        CODE_NONE     = 3'd0,
        CODE_CONFLICT = 3'd1,
        CODE_SHORT    = 3'd2,
        CODE_LONG     = 3'd3,
        CODE_STARVE   = 3'd4
    } code_t;

    localparam logic [CW-1:0] MIN_G = CW'(MIN_GREEN);
    localparam logic [CW-1:0] MAX_G = CW'(MAX_GREEN);
    localparam logic [CW-1:0] MAX_W = CW'(MAX_WAIT);

    state_t        state;
    logic [3:0]    served_mask;
    logic [CW-1:0] wait_cnt [4];

    logic [3:0] act;
    logic [2:0] act_cnt;
    logic       single;
    logic [1:0] sample_dir;
    logic       same_dir;
    logic       phase_end;
    logic       starve_hit;
    code_t      new_code;

    // Bit order matches active_dir encoding: E=0, W=1, N=2, S=3.
    assign act = {s2_l | s2_r | s2_o, n2_l | n2_r | n2_o,
                  w2_l | w2_r | w2_o, e2_l | e2_r | e2_o};

    assign act_cnt = {2'b00, act[0]} + {2'b00, act[1]} + {2'b00, act[2]} + {2'b00, act[3]};
    assign single  = (act_cnt == 3'd1);

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        sample_dir = 2'd0;
        case (act)
            4'b0010: sample_dir = 2'd1;
            4'b0100: sample_dir = 2'd2;
            4'b1000: sample_dir = 2'd3;
            default: sample_dir = 2'd0;
        endcase
    end

    assign same_dir  = (state == ST_SERVE) && single && (sample_dir == active_dir);
    assign phase_end = (state == ST_SERVE) &&
                       ((act_cnt == 3'd0) || (single && (sample_dir != active_dir)));

    always_comb begin
        starve_hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (wait_cnt[k] >= MAX_W) starve_hit = 1'b1;
        end
    end

    // Priority chain: lowest nonzero code wins when several checks trip together.
    always_comb begin
        new_code = CODE_NONE;
        if (act_cnt >= 3'd2)                   new_code = CODE_CONFLICT;
        else if (phase_end && phase_len < MIN_G) new_code = CODE_SHORT;
        else if (same_dir && phase_len == MAX_G) new_code = CODE_LONG;
        else if (starve_hit)                   new_code = CODE_STARVE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            active_valid <= 1'b0;
            active_dir   <= 2'd0;
            phase_len    <= '0;
            round_cnt    <= 8'd0;
            fault        <= 1'b0;
            fault_code   <= CODE_NONE;
            served_mask  <= 4'd0;
            // NOTE: the wait counters are a small register array, so they are reset like any flop.
            for (int k = 0; k < 4; k++) wait_cnt[k] <= '0;
        end else if (state == ST_FAULT) begin
            // Everything is frozen until a clear; the clear also skips checking this sample.
            if (clr_fault) begin
                state        <= ST_IDLE;
                fault        <= 1'b0;
                fault_code   <= CODE_NONE;
                active_valid <= 1'b0;
                phase_len    <= '0;
                served_mask  <= 4'd0;
                for (int k = 0; k < 4; k++) wait_cnt[k] <= '0;
            end
        end else if (new_code != CODE_NONE) begin
            state      <= ST_FAULT;
            fault      <= 1'b1;
            fault_code <= new_code;
        end else begin
            for (int k = 0; k < 4; k++) begin
                wait_cnt[k] <= act[k] ? '0 : wait_cnt[k] + CW'(1);
            end
            if (single) begin
                state        <= ST_SERVE;
                active_valid <= 1'b1;
                if (same_dir) begin
                    phase_len <= phase_len + CW'(1);
                end else begin
                    active_dir <= sample_dir;
                    phase_len  <= CW'(1);
                    if ((served_mask | act) == 4'hF) begin
                        round_cnt   <= round_cnt + 8'd1;
                        served_mask <= 4'd0;
                    end else begin
                        served_mask <= served_mask | act;
                    end
                end
            end else begin
                state        <= ST_IDLE;
                active_valid <= 1'b0;
                phase_len    <= '0;
            end
        end
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Passive safety checker that samples the 12 light outputs of the four-approach traffic light controller and verifies the phase sequencing. It checks for conflicting greens, phases that are too short or too long, and starvation of any approach. It latches a sticky fault with a code, and counts completed service rounds. It sits beside the controller in the top level and drives the fault indication; it never drives the lights.

Parameters:
CW, 8, width of the phase-length and wait counters
MIN_GREEN, 2, minimum consecutive cycles an approach must stay active
MAX_GREEN, 8, maximum consecutive cycles an approach may stay active
MAX_WAIT, 40, maximum cycles an approach may go unserved (must be < 2^CW)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
e2_l, e2_r, e2_o  in  1 each  East approach left/right/opposite go signals
w2_l, w2_r, w2_o  in  1 each  West approach go signals
n2_l, n2_r, n2_o  in  1 each  North approach go signals
s2_l, s2_r, s2_o  in  1 each  South approach go signals
clr_fault  in  1  synchronous fault clear, one-cycle pulse
active_valid  out  1  exactly one approach active in the last sample
active_dir  out  2  served approach: E=0, W=1, N=2, S=3
phase_len  out  CW  consecutive cycles the current approach has been active
round_cnt  out  8  completed rounds, wraps 255->0
fault  out  1  sticky fault flag
fault_code  out  3  0 none, 1 CONFLICT, 2 SHORT_PHASE, 3 LONG_PHASE, 4 STARVE

Behaviour:
- Approach k is active when the OR of its three go signals is 1. Inputs are sampled on every rising clk edge. All outputs are registered.
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, all wait counters 0, served_mask 0. Reset mid-operation aborts everything; nothing is retained.
- States:
  - IDLE: no approach active.
  - SERVE: exactly one approach active.
  - FAULT: sticky.
- IDLE -> SERVE when exactly one approach is active. On entry, active_dir = that approach and phase_len = 1.
- SERVE with the same approach still active: phase_len increments.
- SERVE with a different single approach active (direct switch): the old phase ends. Perform the short-phase check on the old phase, then the new phase starts with phase_len = 1.
- SERVE with no approach active: phase ends (short-phase check), go to IDLE, active_valid = 0, phase_len = 0.
- CONFLICT: two or more approaches active in any sample, in any non-FAULT state.
- SHORT_PHASE: a phase ends with phase_len < MIN_GREEN.
- LONG_PHASE: the same approach is sampled active while phase_len == MAX_GREEN.
- Wait counters: one per approach. Reset to 0 on a cycle its approach is sampled active; otherwise increment. STARVE when any wait counter reaches MAX_WAIT.
- Simultaneous faults: the lowest nonzero code wins (CONFLICT > SHORT > LONG > STARVE).
- Fault timing: fault=1 and fault_code are visible the cycle after the offending sample. The state moves to FAULT.
- In FAULT: phase_len, active_dir, active_valid, round_cnt and the wait counters freeze. Further faults do not change fault_code.
- clr_fault:
  - In FAULT: on the next edge, fault=0, code=0, state IDLE, and phase_len, wait counters and served_mask clear. round_cnt is kept.
  - Outside FAULT: ignored.
  - On the same edge as a new fault condition: the clear wins, and that sample is not checked.
- Rounds: served_mask sets bit k when approach k starts a phase. When all four bits are set, round_cnt increments on that edge and the mask clears to 0. The approach that completed the round is not re-counted in the new mask.

Test Plan:
1. Release reset; drive E, W, N, S one at a time, each for 3 cycles, with 1 idle cycle between -> fault=0 throughout; active_dir steps 0,1,2,3; round_cnt=1 one cycle after S starts.
2. Drive e2_l=1 and n2_o=1 in the same cycle -> next cycle fault=1, fault_code=1. Keep driving lights -> code stays 1 and phase_len is frozen.
3. E active for 1 cycle, then idle -> fault_code=2. Pulse clr_fault -> next cycle fault=0, code=0, round_cnt unchanged.
4. W held active for 9 cycles -> fault_code=3 visible one cycle after the 9th sample (phase_len frozen at 8).
5. Cycle only E and W, 3 cycles each -> STARVE (code 4) one cycle after the N wait counter reaches 40. Assert rst=0 mid-phase -> all outputs 0 immediately.
6. Direct switch N->S with no idle gap, each phase 2 cycles -> no fault; phase_len reads 1 then 2 for S.
